// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the screen sequencer slice.
//   screen_state_t   : 2-bit game-flow state, values fixed for debug LEDs
//   END_SCORE_STEP   : default displayed-score increment per frame in reveal
//   END_MIN_FRAMES   : default hold-off frames before restart is accepted
//   END_BLINK_FRAMES : default frames per half-period of the prompt blink
//   COLOR_WHITE      : 8-bit RGB332 white
package screen_sequencer_pkg;

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_GAME   = 2'd1,
        S_REVEAL = 2'd2,
        S_WAIT   = 2'd3
    } screen_state_t;

    localparam logic [15:0] END_SCORE_STEP   = 16'd5;
    localparam int          END_MIN_FRAMES   = 120;
    localparam int          END_BLINK_FRAMES = 30;

    localparam logic [7:0]  COLOR_WHITE      = 8'hFF;

endpackage

// File: rtl/screen_sequencer_frame_counter.sv
// Frame counter used for the end-screen hold-off and prompt blink.
//   clk, resetN : pixel clock, asynchronous active-low reset
//   clear       : synchronous clear, wins over tick
//   tick        : count enable (one video frame)
//   done        : saturating mode - count has reached LIMIT (level)
//                 wrapping mode   - this tick wraps LIMIT-1 back to 0 (pulse)
module frame_counter #(
    parameter int LIMIT = 120,
    parameter bit WRAP  = 1'b0,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam logic [WIDTH-1:0] LIMIT_W    = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] LIMIT_M1_W = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    generate
        if (WRAP) begin : g_wrap
            assign done = tick && (count_reg == LIMIT_M1_W);

            always_comb begin
                count_next = count_reg;
                if (clear)
                    count_next = '0;
                else if (done)
                    count_next = '0;
                else if (tick)
                    count_next = count_reg + 1'b1;
            end
        end else begin : g_sat
            assign done = (count_reg == LIMIT_W);

            always_comb begin
                count_next = count_reg;
                if (clear)
                    count_next = '0;
                else if (tick && !done)
                    count_next = count_reg + 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow controller: start screen -> gameplay -> animated score reveal
// -> hold-off wait -> start screen. Selects the full-screen RGB layer and
// drives the end screen's counting-up score and blinking prompt.
//   clk, resetN        : pixel clock, asynchronous active-low reset
//   startOfFrame       : one-cycle pulse per video frame
//   keyStart, gameOver : one-cycle control pulses
//   score              : live binary score from game logic
//   RGB_screen_start/RGB_game/RGB_screen_end : layer pixels
//   RGBOut             : selected pixel (combinational from state)
//   scoreShown         : score value for the end-screen number block
//   gameActive         : high in S_GAME
//   promptVisible      : end-screen "press key" enable (blinks in S_WAIT)
//   screenState        : current state for debug/LEDs
module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter logic [15:0] SCORE_STEP     = END_SCORE_STEP,
    parameter int          MIN_END_FRAMES = END_MIN_FRAMES,
    parameter int          BLINK_FRAMES   = END_BLINK_FRAMES
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        keyStart,
    input  logic        gameOver,
    input  logic [15:0] score,
    input  logic [7:0]  RGB_screen_start,
    input  logic [7:0]  RGB_game,
    input  logic [7:0]  RGB_screen_end,
    output logic [7:0]  RGBOut,
    output logic [15:0] scoreShown,
    output logic        gameActive,
    output logic        promptVisible,
    output logic [1:0]  screenState
);

    screen_state_t state_reg, state_next;
    logic [15:0]   score_shown_reg, score_shown_next;
    logic [15:0]   final_score_reg, final_score_next;
    logic          prompt_reg;
    logic          hold_clear;
    logic          hold_done;
    logic          blink_done;
    logic          wait_tick;
    logic [16:0]   reveal_sum;

    // 17-bit sum so a final score near 16'hFFFF cannot wrap past the target
    assign reveal_sum = {1'b0, score_shown_reg} + {1'b0, SCORE_STEP};
    assign wait_tick  = startOfFrame && (state_reg == S_WAIT);

    always_comb begin
        state_next       = state_reg;
        score_shown_next = score_shown_reg;
        final_score_next = final_score_reg;
        hold_clear       = 1'b0;
        case (state_reg)
            S_START: begin
                if (keyStart)
                    state_next = S_GAME;
            end
            S_GAME: begin
                // gameOver is checked alone; a coincident keyStart has no role here
                if (gameOver) begin
                    final_score_next = score;
                    score_shown_next = '0;
                    hold_clear       = 1'b1;
                    state_next       = S_REVEAL;
                end
            end
            S_REVEAL: begin
                if (keyStart) begin
                    score_shown_next = final_score_reg;
                    hold_clear       = 1'b1;
                    state_next       = S_WAIT;
                end else if (startOfFrame) begin
                    if (reveal_sum >= {1'b0, final_score_reg}) begin
                        score_shown_next = final_score_reg;
                        hold_clear       = 1'b1;
                        state_next       = S_WAIT;
                    end else begin
                        score_shown_next = reveal_sum[15:0];
                    end
                end
            end
            S_WAIT: begin
                if (keyStart && hold_done) begin
                    score_shown_next = '0;
                    state_next       = S_START;
                end
            end
            default: state_next = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg       <= S_START;
            score_shown_reg <= '0;
            final_score_reg <= '0;
            prompt_reg      <= 1'b1;
        end else begin
            state_reg       <= state_next;
            score_shown_reg <= score_shown_next;
            final_score_reg <= final_score_next;
            if (state_reg != S_WAIT)
                prompt_reg <= 1'b1;
            else if (blink_done)
                prompt_reg <= ~prompt_reg;
        end
    end

    // Hold-off: saturates at MIN_END_FRAMES, cleared on entry to S_WAIT
    frame_counter #(
        .LIMIT (MIN_END_FRAMES),
        .WRAP  (1'b0)
    ) u_hold_cnt (
        .clk    (clk),
        .resetN (resetN),
        .clear  (hold_clear),
        .tick   (wait_tick),
        .done   (hold_done)
    );

    // Blink: wraps every BLINK_FRAMES frames, held at zero outside S_WAIT
    frame_counter #(
        .LIMIT (BLINK_FRAMES),
        .WRAP  (1'b1)
    ) u_blink_cnt (
        .clk    (clk),
        .resetN (resetN),
        .clear  (state_reg != S_WAIT),
        .tick   (wait_tick),
        .done   (blink_done)
    );

    always_comb begin
        case (state_reg)
            S_START: RGBOut = RGB_screen_start;
            S_GAME:  RGBOut = RGB_game;
            default: RGBOut = RGB_screen_end;
        endcase
    end

    assign scoreShown    = score_shown_reg;
    assign gameActive    = (state_reg == S_GAME);
    // Forced high outside S_WAIT so leaving the wait never shows a stale blink phase
    assign promptVisible = (state_reg != S_WAIT) || prompt_reg;
    assign screenState   = state_reg;

endmodule

// File: tb/tb_screen_sequencer.sv
module tb_screen_sequencer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        keyStart;
    logic        gameOver;
    logic [15:0] score;
    logic [7:0]  RGB_screen_start;
    logic [7:0]  RGB_game;
    logic [7:0]  RGB_screen_end;
    logic [7:0]  RGBOut;
    logic [15:0] scoreShown;
    logic        gameActive;
    logic        promptVisible;
    logic [1:0]  screenState;

    int checks = 0;
    int errors = 0;

    screen_sequencer dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .keyStart         (keyStart),
        .gameOver         (gameOver),
        .score            (score),
        .RGB_screen_start (RGB_screen_start),
        .RGB_game         (RGB_game),
        .RGB_screen_end   (RGB_screen_end),
        .RGBOut           (RGBOut),
        .scoreShown       (scoreShown),
        .gameActive       (gameActive),
        .promptVisible    (promptVisible),
        .screenState      (screenState)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given pulses; outputs settle 1 time unit after the edge
    task automatic step(input logic sof, input logic key, input logic go);
        @(negedge clk);
        startOfFrame = sof;
        keyStart     = key;
        gameOver     = go;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        keyStart     = 1'b0;
        gameOver     = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        resetN           = 1'b0;
        startOfFrame     = 1'b0;
        keyStart         = 1'b0;
        gameOver         = 1'b0;
        score            = 16'd0;
        RGB_screen_start = 8'h11;
        RGB_game         = 8'h22;
        RGB_screen_end   = 8'h33;
        #2;
        chk("rst_state",  32'(screenState),   32'd0);
        chk("rst_active", 32'(gameActive),    32'd0);
        chk("rst_prompt", 32'(promptVisible), 32'd1);
        chk("rst_shown",  32'(scoreShown),    32'd0);
        chk("rst_rgb",    32'(RGBOut),        32'h11);
        @(negedge clk);
        resetN = 1'b1;

        // start -> game
        step(1'b0, 1'b1, 1'b0);
        $display("key in START -> state %0d", screenState);
        chk("game_state",  32'(screenState), 32'd1);
        chk("game_active", 32'(gameActive),  32'd1);
        chk("game_rgb",    32'(RGBOut),      32'h22);

        // reveal of 23 in steps of 5
        score = 16'd23;
        step(1'b0, 1'b0, 1'b1);
        $display("gameOver score=23 -> state %0d shown %0d", screenState, scoreShown);
        chk("rev_state", 32'(screenState), 32'd2);
        chk("rev_shown0", 32'(scoreShown), 32'd0);
        chk("rev_rgb",   32'(RGBOut),      32'h33);
        chk("rev_inactive", 32'(gameActive), 32'd0);
        frames(1); chk("rev_s5",  32'(scoreShown), 32'd5);
        frames(1); chk("rev_s10", 32'(scoreShown), 32'd10);
        frames(1); chk("rev_s15", 32'(scoreShown), 32'd15);
        frames(1); chk("rev_s20", 32'(scoreShown), 32'd20);
        chk("rev_still", 32'(screenState), 32'd2);
        frames(1); chk("rev_s23", 32'(scoreShown), 32'd23);
        $display("reveal done -> state %0d shown %0d", screenState, scoreShown);
        chk("wait_state", 32'(screenState), 32'd3);
        chk("wait_rgb",   32'(RGBOut),      32'h33);
        chk("wait_prompt0", 32'(promptVisible), 32'd1);

        // hold-off and blink
        frames(29); chk("blink_f29", 32'(promptVisible), 32'd1);
        frames(1);  chk("blink_f30", 32'(promptVisible), 32'd0);
        frames(20);
        step(1'b0, 1'b1, 1'b0);
        $display("key at frame 50 -> state %0d", screenState);
        chk("key_f50_ignored", 32'(screenState), 32'd3);
        frames(9);  chk("blink_f59", 32'(promptVisible), 32'd0);
        frames(1);  chk("blink_f60", 32'(promptVisible), 32'd1);
        frames(59); chk("blink_f119", 32'(promptVisible), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("key_f119_ignored", 32'(screenState), 32'd3);
        frames(1);  chk("blink_f120", 32'(promptVisible), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        $display("key at frame 120 -> state %0d shown %0d", screenState, scoreShown);
        chk("restart_state", 32'(screenState), 32'd0);
        chk("restart_shown", 32'(scoreShown),  32'd0);
        chk("restart_rgb",   32'(RGBOut),      32'h11);
        chk("restart_prompt", 32'(promptVisible), 32'd1);

        // saturation near the top of the range
        step(1'b0, 1'b1, 1'b0);
        score = 16'hFFFE;
        step(1'b0, 1'b0, 1'b1);
        frames(13106);
        chk("sat_pre",       32'(scoreShown),  32'hFFFA);
        chk("sat_pre_state", 32'(screenState), 32'd2);
        frames(1);
        $display("reveal FFFE last step -> shown %0h state %0d", scoreShown, screenState);
        chk("sat_shown", 32'(scoreShown),  32'hFFFE);
        chk("sat_state", 32'(screenState), 32'd3);
        frames(1);
        chk("sat_hold", 32'(scoreShown), 32'hFFFE);
        frames(120);
        step(1'b0, 1'b1, 1'b0);
        chk("sat_restart", 32'(screenState), 32'd0);

        // skip with key coinciding with a frame pulse
        step(1'b0, 1'b1, 1'b0);
        score = 16'd40;
        step(1'b0, 1'b0, 1'b1);
        frames(2);
        chk("skip_pre", 32'(scoreShown), 32'd10);
        step(1'b1, 1'b1, 1'b0);
        $display("key+frame in reveal -> shown %0d state %0d", scoreShown, screenState);
        chk("skip_shown", 32'(scoreShown),  32'd40);
        chk("skip_state", 32'(screenState), 32'd3);
        frames(120);
        step(1'b0, 1'b1, 1'b0);
        chk("skip_restart", 32'(screenState), 32'd0);

        // gameOver and keyStart together, zero final score
        step(1'b0, 1'b1, 1'b0);
        score = 16'd0;
        step(1'b0, 1'b1, 1'b1);
        $display("gameOver+key in GAME -> state %0d", screenState);
        chk("go_wins_state", 32'(screenState), 32'd2);
        frames(1);
        chk("zero_exit_state", 32'(screenState), 32'd3);
        chk("zero_exit_shown", 32'(scoreShown),  32'd0);
        frames(120);
        step(1'b0, 1'b1, 1'b0);

        // asynchronous reset in the middle of a reveal
        step(1'b0, 1'b1, 1'b0);
        score = 16'd100;
        step(1'b0, 1'b0, 1'b1);
        frames(2);
        chk("mid_rev_shown", 32'(scoreShown), 32'd10);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        $display("async reset mid-reveal -> state %0d shown %0d", screenState, scoreShown);
        chk("arst_state",  32'(screenState),   32'd0);
        chk("arst_shown",  32'(scoreShown),    32'd0);
        chk("arst_active", 32'(gameActive),    32'd0);
        chk("arst_prompt", 32'(promptVisible), 32'd1);
        chk("arst_rgb",    32'(RGBOut),        32'h11);
        @(negedge clk);
        resetN = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        chk("post_rst_game", 32'(screenState), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level game-flow controller that decides which full-screen layer reaches the VGA output and drives the end screen. It moves through start screen, gameplay, animated end-screen score reveal and a hold-off period before restart. It latches the final score on game over and feeds a counting-up score to the end screen's number block, one step per video frame. It sits between the game logic, the three screen RGB sources and the VGA driver.

## Interface
- `SCORE_STEP`, 16'd5: amount added to the displayed score per frame during reveal.
- `MIN_END_FRAMES`, 120: frames after reveal completes before `keyStart` is honoured.
- `BLINK_FRAMES`, 30: frames per half-period of the end-screen prompt blink.
- `clk` in 1: pixel clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `keyStart` in 1: debounced one-cycle key pulse.
- `gameOver` in 1: one-cycle pulse from game logic.
- `score` in 16: live binary score.
- `RGB_screen_start` in 8: start-screen pixel.
- `RGB_game` in 8: gameplay pixel.
- `RGB_screen_end` in 8: end-screen pixel.
- `RGBOut` out 8: selected pixel.
- `scoreShown` out 16: score value passed to the end screen.
- `gameActive` out 1: high while in S_GAME; enables ball and flipper logic.
- `promptVisible` out 1: end-screen "press key" word enable.
- `screenState` out 2: current state, for debug and LEDs.

## Operation
- States: S_START=0, S_GAME=1, S_REVEAL=2, S_WAIT=3.
- **S_START:** `keyStart` moves to S_GAME.
- **S_GAME:** `gameOver` does the following, then moves to S_REVEAL:
  - latches `score` into `finalScore`;
  - clears `scoreShown` and `frameCnt`.
  - If `gameOver` and `keyStart` arrive in the same cycle, `gameOver` wins.
- **S_REVEAL:** on each `startOfFrame`, `scoreShown` ← min(`scoreShown`+`SCORE_STEP`, `finalScore`).
  - The sum is computed 17 bits wide, so there is no wrap at 16'hFFFF.
  - When the new value equals `finalScore`, move to S_WAIT and clear `frameCnt`.
  - With `finalScore`=0, exit on the first `startOfFrame`.
  - `keyStart` skips the reveal: `scoreShown` ← `finalScore`, move to S_WAIT, clear `frameCnt`. If `keyStart` and `startOfFrame` coincide, `keyStart` takes precedence.
- **S_WAIT:**
  - On each `startOfFrame`, `frameCnt` increments and saturates at `MIN_END_FRAMES`.
  - `keyStart` is ignored while `frameCnt` < `MIN_END_FRAMES`.
  - Once `frameCnt` reaches `MIN_END_FRAMES`, `keyStart` moves to S_START and clears `scoreShown`.
- **Blink:**
  - `blinkCnt` counts `startOfFrame` pulses in S_WAIT only.
  - When `blinkCnt` reaches `BLINK_FRAMES`−1 on a frame pulse, `blinkCnt` clears and `promptVisible` toggles.
  - `promptVisible` is forced to 1 in all other states.
- **RGB mux:**
  - S_START selects `RGB_screen_start`.
  - S_GAME selects `RGB_game`.
  - S_REVEAL and S_WAIT select `RGB_screen_end`.
- `gameActive` is 1 exactly when the state is S_GAME.
- `finalScore` keeps its value until the next `gameOver`.

## Timing
- Reset values:
  - state S_START;
  - `scoreShown`, `finalScore`, `frameCnt`, `blinkCnt` all 0;
  - `gameActive` 0, `promptVisible` 1, `screenState` 0.
- An asynchronous reset mid-reveal or mid-wait returns immediately to these values.
- State, counters, `scoreShown` and `promptVisible` are registered and update on the clock edge after the qualifying input pulse, i.e. 1-cycle latency.
- `gameActive` and `screenState` decode the state register directly, with no extra delay.
- `RGBOut` is a combinational mux from the state register (0 added latency), so pixel alignment with the RGB sources is preserved.
- Inputs are single-cycle pulses; a held level counts on every cycle it is high. Upstream guarantees pulses.

## Structure
- The shared defines package holds:
  - `screen_state_t` enum (2-bit);
  - default `END_SCORE_STEP`, `END_MIN_FRAMES`, `END_BLINK_FRAMES`;
  - `COLOR_WHITE`, already present.
- One sub-module, `frame_counter`: a saturating/wrapping counter parameterised by limit, with `clear`, `tick` (= `startOfFrame`) and `done` outputs. It is instantiated twice, for the hold-off and the blink.

## Test plan
- Reset, then `keyStart` → `screenState` 1 and `gameActive` 1 next cycle; `RGBOut` equals `RGB_game`.
- Set `score`=23, pulse `gameOver`, then 5 frames → `scoreShown` steps 5, 10, 15, 20, 23, then the state is S_WAIT.
- `score`=16'hFFFE, step 5 → `scoreShown` saturates at 16'hFFFE with no wrap, and the state moves to S_WAIT.
- In S_REVEAL at `scoreShown`=10, send `keyStart` together with `startOfFrame` → next cycle `scoreShown`=`finalScore` and the state is S_WAIT.
- In S_WAIT:
  - `keyStart` at frame 50 → ignored;
  - at frame 120 → S_START with `scoreShown` 0;
  - `promptVisible` toggles every 30 frames.
- Assert `resetN` low mid-S_REVEAL → all outputs at their reset values asynchronously; `RGBOut` equals `RGB_screen_start`.
